// File: rtl/regfile_mp_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_scoreboard
//  Description : Multi-read-port integer register file with an optional
//                hardwired-zero register, optional same-cycle write-to-read
//                bypass and a per-register busy scoreboard for decode stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp_scoreboard #(
    parameter int DataWidth    = 32,
    parameter int RegAddress   = 5,
    parameter int NumReadPorts = 2,
    parameter int ZeroReg      = 1,
    parameter int BypassEn     = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               write_enable,
    input  logic [RegAddress-1:0]              write_addr,
    input  logic [DataWidth-1:0]               write_data,
    input  logic                               issue_enable,
    input  logic [RegAddress-1:0]              issue_addr,
    input  logic [NumReadPorts*RegAddress-1:0] read_addr,
    output logic [NumReadPorts*DataWidth-1:0]  read_data,
    output logic [NumReadPorts-1:0]            read_ready,
    output logic [(2**RegAddress)-1:0]         busy_vec
);

    localparam int c_NUM_REGS = 2**RegAddress;

    logic [DataWidth-1:0]  r_regs [c_NUM_REGS];
    logic [c_NUM_REGS-1:0] r_busy;

    logic                  w_write_ok;
    logic                  w_issue_ok;
    logic [c_NUM_REGS-1:0] w_set_vec;
    logic [c_NUM_REGS-1:0] w_clr_vec;

    // Writes and issues to the hardwired-zero register are dropped here, so
    // neither storage nor scoreboard can ever observe them. Reset masks both
    // strobes so forwarding is also suppressed in the reset cycle.
    assign w_write_ok = rst && write_enable
                        && !((ZeroReg != 0) && (write_addr == '0));
    assign w_issue_ok = rst && issue_enable
                        && !((ZeroReg != 0) && (issue_addr == '0));

    assign w_set_vec = w_issue_ok
                       ? ({{(c_NUM_REGS-1){1'b0}}, 1'b1} << issue_addr) : '0;
    assign w_clr_vec = w_write_ok
                       ? ({{(c_NUM_REGS-1){1'b0}}, 1'b1} << write_addr) : '0;

    // Register storage and scoreboard; a new issue overrides a completing
    // writeback to the same register because the newer producer is pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_write_ok) begin
                r_regs[write_addr] <= write_data;
            end
            r_busy <= (r_busy & ~w_clr_vec) | w_set_vec;
        end
    end

    assign busy_vec = r_busy;

    for (genvar k = 0; k < NumReadPorts; k++) begin : g_read_port
        logic [RegAddress-1:0] w_addr;
        logic                  w_is_zero;
        logic                  w_wr_hit;
        logic                  w_set_hit;

        assign w_addr    = read_addr[k*RegAddress +: RegAddress];
        assign w_is_zero = (ZeroReg != 0) && (w_addr == '0);
        assign w_wr_hit  = (BypassEn != 0) && w_write_ok && (write_addr == w_addr);
        assign w_set_hit = w_issue_ok && (issue_addr == w_addr);

        assign read_data[k*DataWidth +: DataWidth] =
            w_is_zero ? '0 : (w_wr_hit ? write_data : r_regs[w_addr]);

        // A forwarded writeback makes the value current unless a newer
        // producer for the same register issues in the same cycle.
        assign read_ready[k] = w_is_zero || !r_busy[w_addr] || (w_wr_hit && !w_set_hit);
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp_scoreboard
//  Description : Self-checking bench for regfile_mp_scoreboard. Two instances
//                share one stimulus stream: configuration 0 has the zero
//                register and bypass, configuration 1 has neither.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [9:0]  ra;

    logic [63:0] rd_a, rd_b;
    logic [1:0]  rdy_a, rdy_b;
    logic [31:0] busy_a, busy_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference state: one flat memory and busy table per configuration.
    logic [31:0] m_mem  [2][32];
    bit          m_busy [2][32];

    always #5 clk = ~clk;

    regfile_mp_scoreboard #(
        .DataWidth(32), .RegAddress(5), .NumReadPorts(2), .ZeroReg(1), .BypassEn(1)
    ) dut (
        .clk(clk), .rst(rst), .write_enable(we), .write_addr(wa), .write_data(wd),
        .issue_enable(ie), .issue_addr(ia), .read_addr(ra),
        .read_data(rd_a), .read_ready(rdy_a), .busy_vec(busy_a)
    );

    regfile_mp_scoreboard #(
        .DataWidth(32), .RegAddress(5), .NumReadPorts(2), .ZeroReg(0), .BypassEn(0)
    ) dut_b (
        .clk(clk), .rst(rst), .write_enable(we), .write_addr(wa), .write_data(wd),
        .issue_enable(ie), .issue_addr(ia), .read_addr(ra),
        .read_data(rd_b), .read_ready(rdy_b), .busy_vec(busy_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input int c, input logic [4:0] a);
        bit zr  = (c == 0);
        bit byp = (c == 0);
        bit wr  = rst && we && !(zr && wa == 5'd0);
        if (zr && a == 5'd0) return 32'd0;
        if (byp && wr && wa == a) return wd;
        return m_mem[c][a];
    endfunction

    function automatic logic [31:0] exp_ready(input int c, input logic [4:0] a);
        bit zr  = (c == 0);
        bit byp = (c == 0);
        bit wr  = rst && we && !(zr && wa == 5'd0);
        if (zr && a == 5'd0) return 32'd1;
        if (!m_busy[c][a]) return 32'd1;
        return {31'd0, byp && wr && wa == a && !(rst && ie && ia == a)};
    endfunction

    function automatic logic [31:0] exp_busy(input int c);
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[c][i];
        return v;
    endfunction

    // Reference update: apply the writeback, then the issue, so the issue wins.
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (!rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[c][i]  <= 32'd0;
                    m_busy[c][i] <= 1'b0;
                end
            end else begin
                if (we && !(c == 0 && wa == 5'd0)) begin
                    m_mem[c][wa]  <= wd;
                    m_busy[c][wa] <= 1'b0;
                end
                if (ie && !(c == 0 && ia == 5'd0)) m_busy[c][ia] <= 1'b1;
            end
        end
    end

    // Continuous comparison against the reference on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_data_a%0d", k), rd_a[k*32 +: 32], exp_data(0, ra[k*5 +: 5]));
                chk($sformatf("model_data_b%0d", k), rd_b[k*32 +: 32], exp_data(1, ra[k*5 +: 5]));
                chk($sformatf("model_ready_a%0d", k), {31'd0, rdy_a[k]}, exp_ready(0, ra[k*5 +: 5]));
                chk($sformatf("model_ready_b%0d", k), {31'd0, rdy_b[k]}, exp_ready(1, ra[k*5 +: 5]));
            end
            chk("model_busy_a", busy_a, exp_busy(0));
            chk("model_busy_b", busy_b, exp_busy(1));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; ie = 1'b0;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0; ie = 1'b0; ia = '0; ra = '0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b1;

        // Post-reset sweep of all registers on both ports.
        for (int r = 0; r < 32; r++) begin
            ra = {r[4:0], r[4:0]};
            @(negedge clk);
            chk("rst_data_p0", rd_a[31:0], 32'd0);
            chk("rst_data_p1", rd_a[63:32], 32'd0);
            chk("rst_ready", {30'd0, rdy_a}, 32'd3);
            chk("rst_busy", busy_a, 32'd0);
            cyc();
        end

        // Plain write then read on both ports.
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = {5'd0, 5'd0};
        cyc();
        idle(); ra = {5'd5, 5'd5};
        @(negedge clk);
        chk("wr_x5_p0", rd_a[31:0], 32'hDEADBEEF);
        chk("wr_x5_p1", rd_a[63:32], 32'hDEADBEEF);
        cyc();

        // Write plus issue to x0.
        we = 1'b1; wa = 5'd0; wd = 32'h12345678; ie = 1'b1; ia = 5'd0;
        cyc();
        idle(); ra = {5'd0, 5'd0};
        @(negedge clk);
        chk("x0_zero_data", rd_a[31:0], 32'd0);
        chk("x0_zero_busy", {31'd0, busy_a[0]}, 32'd0);
        chk("x0_plain_data", rd_b[31:0], 32'h12345678);
        cyc();

        // Same-cycle bypass versus old value.
        we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra = {5'd7, 5'd7};
        @(negedge clk);
        chk("byp_same_cycle", rd_a[31:0], 32'hA5A5A5A5);
        chk("nobyp_old_value", rd_b[31:0], 32'd0);
        cyc();
        idle();
        @(negedge clk);
        chk("nobyp_next_cycle", rd_b[31:0], 32'hA5A5A5A5);
        cyc();

        // Scoreboard sequence on x9.
        ie = 1'b1; ia = 5'd9; ra = {5'd9, 5'd9};
        cyc();
        idle();
        @(negedge clk);
        chk("sb_issue_busy", {31'd0, busy_a[9]}, 32'd1);
        chk("sb_issue_ready", {31'd0, rdy_a[0]}, 32'd0);
        cyc();
        we = 1'b1; wa = 5'd9; wd = 32'h55;
        @(negedge clk);
        chk("sb_wb_ready_byp", {31'd0, rdy_a[0]}, 32'd1);
        chk("sb_wb_ready_nobyp", {31'd0, rdy_b[0]}, 32'd0);
        cyc();
        idle();
        @(negedge clk);
        chk("sb_wb_busy", {31'd0, busy_a[9]}, 32'd0);
        chk("sb_wb_data", rd_a[31:0], 32'h55);
        cyc();
        ie = 1'b1; ia = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h66;
        @(negedge clk);
        chk("sb_both_ready", {31'd0, rdy_a[0]}, 32'd1);
        cyc();
        idle();
        @(negedge clk);
        chk("sb_both_busy_a", {31'd0, busy_a[9]}, 32'd1);
        chk("sb_both_busy_b", {31'd0, busy_b[9]}, 32'd1);
        cyc();

        // Mid-operation reset with an in-flight producer.
        ie = 1'b1; ia = 5'd3;
        cyc();
        idle();
        @(negedge clk);
        chk("mid_busy_x3", {31'd0, busy_a[3]}, 32'd1);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy_a, 32'd0);
        we = 1'b1; wa = 5'd3; wd = 32'h77;
        cyc();
        idle(); ra = {5'd3, 5'd3};
        @(negedge clk);
        chk("mid_x3_data", rd_a[63:32], 32'h77);
        chk("mid_x3_busy", busy_a, 32'd0);
        cyc();

        // Randomised traffic, biased toward a few registers to force hits.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            we  = $urandom_range(0, 1);
            ie  = $urandom_range(0, 2) == 0;
            wa  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            ia  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wd  = $urandom;
            ra[4:0] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            ra[9:5] = ($urandom_range(0, 3) == 0) ? ra[4:0] : 5'($urandom_range(0, 3));
            cyc();
        end
        rst = 1'b1; idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp_scoreboard.md
Name: regfile_mp_scoreboard

Overview:
Parametrised successor to the single-write, two-read integer register file for the rv32i core. It provides a configurable number of read ports and an optional hardwired-zero register 0. Optional same-cycle write-to-read bypass removes the writeback-to-decode hazard bubble. A per-register busy scoreboard lets decode stall on pending writebacks.

Parameters:
DataWidth, 32, register width in bits
RegAddress, 5, address width; register count = 2**RegAddress
NumReadPorts, 2, number of independent read ports (1..4)
ZeroReg, 1, 1 = register 0 reads 0, ignores writes and is never busy; 0 = register 0 is an ordinary register
BypassEn, 1, 1 = same-cycle write data is forwarded to matching read ports

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous active-low reset, sampled on rising edge of clk
write_enable  input  1  writeback strobe
write_addr  input  RegAddress  writeback destination register
write_data  input  DataWidth  writeback data
issue_enable  input  1  instruction issued this cycle that will write issue_addr
issue_addr  input  RegAddress  destination register of the issued instruction
read_addr  input  NumReadPorts*RegAddress  packed read addresses; port k = bits [k*RegAddress +: RegAddress]
read_data  output  NumReadPorts*DataWidth  packed read data, same packing as read_addr
read_ready  output  NumReadPorts  per port: 1 = read_data is the architecturally current value
busy_vec  output  2**RegAddress  scoreboard busy bit per register, for debug and stall logic

Behaviour:
- Reset (rst=0 at a rising edge):
  - All registers cleared to 0 and all busy bits cleared.
  - write_enable and issue_enable are ignored during that cycle.
  - The cycle after reset: every read_data = 0, read_ready = all ones, busy_vec = 0.
- Write: when write_enable=1, reg[write_addr] <= write_data at the rising edge.
  - If ZeroReg=1 and write_addr=0, the write is dropped.
- Read: combinational, zero-latency.
  - read_data[k] = reg[read_addr[k]], unless bypass applies.
  - If ZeroReg=1 and read_addr[k]=0, read_data[k] = 0 regardless of bypass.
- Bypass (BypassEn=1):
  - If write_enable=1 and write_addr = read_addr[k] (and not the zero register), read_data[k] = write_data in the same cycle.
  - If BypassEn=0, the old value is returned until the next cycle.
- Scoreboard, evaluated at each rising edge per register r:
  - set_r = issue_enable and issue_addr=r
  - clr_r = write_enable and write_addr=r
  - set_r has priority over clr_r, so the busy bit stays 1 when both occur: a new producer supersedes the completing one.
  - set_r only → busy 1; clr_r only → busy 0; neither → hold.
  - Register 0 is never set when ZeroReg=1.
  - A clear on a non-busy register is legal and has no effect.
- read_ready[k] = NOT busy[read_addr[k]], OR (BypassEn=1 AND clr for that address this cycle AND no set for it this cycle).
  - Always 1 for the zero register when ZeroReg=1.
- Multiple read ports may address the same register; all return identical data and ready.
- Mid-operation reset clears data and scoreboard regardless of in-flight writebacks. A later write_enable with no matching busy bit still updates the register.
- No X propagation: all storage is reset; addresses are full-width, so there is no out-of-range case.

Test Plan:
1. Reset then read all 32 registers via both ports → read_data=0, read_ready=1, busy_vec=0.
2. Write 0xDEADBEEF to x5, next cycle read x5 on port0 and port1 → both 0xDEADBEEF.
3. ZeroReg=1:
   - Write 0x12345678 to x0 with issue_enable on x0 → x0 reads 0, busy_vec[0]=0.
   - ZeroReg=0 variant: x0 reads 0x12345678.
4. BypassEn=1: write 0xA5A5A5A5 to x7 while reading x7 in the same cycle → read_data=0xA5A5A5A5 that cycle.
   - BypassEn=0 variant: old value returned that cycle, new value the next cycle.
5. Scoreboard sequence on x9:
   - Issue x9 → busy_vec[9]=1 next cycle and read_ready=0 for x9.
   - Writeback x9=0x55 → busy 0 next cycle; with bypass, read_ready=1 in the writeback cycle.
   - Issue and writeback x9 in the same cycle → busy stays 1.
6. Issue x3, then assert rst=0 for one cycle, then writeback x3=0x77 → busy_vec=0 after reset and x3 reads 0x77 after the write.
